// File: rtl/serial_chunk_adder_pkg.sv
// Shared types for serial_chunk_adder: FSM state encoding and
// the helper that sizes the chunk index register.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    // Width of the chunk index; at least one bit even for NCHUNK=1.
    function automatic int idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/serial_chunk_adder_if.sv
// Operand/result handshake bundle for serial_chunk_adder.
// master: producer/consumer side; slave: the adder. Optional sub
// signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/chunk_adder.sv
// CHUNK-bit combinational ripple adder of full-adder cells.
// Ports: a_i, b_i, c_i in; s_o sum, c_o carry out, cmsb_o carry into MSB.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] s_o,
    output logic             c_o,
    output logic             cmsb_o
);
    logic [CHUNK:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o    = c[CHUNK];
    assign cmsb_o = c[CHUNK-1];

endmodule

// File: rtl/serial_chunk_adder.sv
// Serial adder: sums two WIDTH-bit operands CHUNK bits per clock,
// rippling carry through a register; reports cout and signed ovf.
// Ports: clk, rst_n (async active-low), bus (serial_chunk_adder_if.slave).
// Macro SERIAL_ADDER_SUB_EN adds bus.sub for a - b.
module serial_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_chunk_adder_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = idx_w(NCHUNK);

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("serial_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    state_e           state_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic [CHUNK-1:0] cs;
    logic             co;
    logic             cm;
    logic             last;

    assign ca   = a_q[int'(idx_q)*CHUNK +: CHUNK];
    assign cb   = b_q[int'(idx_q)*CHUNK +: CHUNK];
    assign last = (idx_q == IW'(NCHUNK - 1));

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a_i    (ca),
        .b_i    (cb),
        .c_i    (carry_q),
        .s_o    (cs),
        .c_o    (co),
        .cmsb_o (cm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
`ifdef SERIAL_ADDER_SUB_EN
                        // a - b == a + ~b + 1; cin is ignored then
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub | bus.cin;
`else
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
`endif
                        idx_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    sum_q[int'(idx_q)*CHUNK +: CHUNK] <= cs;
                    carry_q <= co;
                    idx_q   <= idx_q + 1'b1;
                    if (last) begin
                        cout_q  <= co;
                        ovf_q   <= cm ^ co;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Randomized self-checking bench for serial_chunk_adder (CHUNK=4 and
// CHUNK=16 instances) against an arithmetic reference model.
module tb_serial_chunk_adder;

    logic clk = 1'b0;
    logic rst_n;
    logic sub_r;

    always #5 clk = ~clk;

    serial_chunk_adder_if #(.WIDTH(16)) bus0 ();
    serial_chunk_adder_if #(.WIDTH(16)) bus1 ();

`ifdef SERIAL_ADDER_SUB_EN
    assign bus0.sub = sub_r;
    assign bus1.sub = sub_r;
`endif

    serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    serial_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain 17-bit arithmetic.
    function automatic logic [17:0] model(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic cin,
                                          input logic sub);
        logic [15:0] bb;
        logic        c;
        logic [16:0] t;
        logic        v;
        bb = sub ? ~b : b;
        c  = sub ? 1'b1 : cin;
        t  = {1'b0, a} + {1'b0, bb} + {16'd0, c};
        v  = (a[15] == bb[15]) && (t[15] != a[15]);
        return {v, t[16], t[15:0]};
    endfunction

    task automatic drive(input int u, input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic cin);
        if (u == 0) begin
            bus0.in_valid = v; bus0.a = a; bus0.b = b; bus0.cin = cin;
        end else begin
            bus1.in_valid = v; bus1.a = a; bus1.b = b; bus1.cin = cin;
        end
    endtask

    task automatic set_rdy(input int u, input logic r);
        if (u == 0) bus0.out_ready = r;
        else        bus1.out_ready = r;
    endtask

    // {in_ready, out_valid, ovf, cout, sum}
    function automatic logic [19:0] rd(input int u);
        if (u == 0)
            return {bus0.in_ready, bus0.out_valid, bus0.ovf, bus0.cout, bus0.sum};
        return {bus1.in_ready, bus1.out_valid, bus1.ovf, bus1.cout, bus1.sum};
    endfunction

    task automatic wait_valid(input int u, output int lat);
        logic [19:0] r;
        lat = 0;
        r = rd(u);
        while (!r[18] && lat < 64) begin
            @(negedge clk);
            lat++;
            r = rd(u);
        end
        if (!r[18]) check("out_valid_timeout", 32'(r[18]), 32'd1);
    endtask

    task automatic op(input int u, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic [17:0] exp,
                      input int lat_exp, input int dly);
        int lat;
        logic [19:0] r;
        @(negedge clk);
        drive(u, 1'b1, a, b, cin);
        r = rd(u);
        check("in_ready_idle", 32'(r[19]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive(u, 1'b0, a, b, cin);
        wait_valid(u, lat);
        r = rd(u);
        check("latency", lat, lat_exp);
        check("sum", 32'(r[15:0]), 32'(exp[15:0]));
        check("cout", 32'(r[16]), 32'(exp[16]));
        check("ovf", 32'(r[17]), 32'(exp[17]));
        check("in_ready_done", 32'(r[19]), 32'd0);
        repeat (dly) @(negedge clk);
        r = rd(u);
        check("sum_hold", 32'(r[15:0]), 32'(exp[15:0]));
        set_rdy(u, 1'b1);
        @(negedge clk);
        set_rdy(u, 1'b0);
        r = rd(u);
        check("out_valid_drop", 32'(r[18]), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] r;
        logic [15:0] ra, rb;
        logic        rc;
        int          lat;

        rst_n = 1'b0;
        sub_r = 1'b0;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
        set_rdy(0, 1'b0);
        set_rdy(1, 1'b0);
        repeat (2) @(negedge clk);
        r = rd(0);
        check("rst_in_ready", 32'(r[19]), 32'd1);
        check("rst_out_valid", 32'(r[18]), 32'd0);
        check("rst_sum", 32'(r[15:0]), 32'd0);
        check("rst_cout_ovf", 32'(r[17:16]), 32'd0);
        rst_n = 1'b1;

        op(0, 16'h1234, 16'h0FFF, 1'b0, {1'b0, 1'b0, 16'h2233}, 4, 0);
        op(0, 16'hFFFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h0000}, 4, 1);
        op(0, 16'h7FFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h8000}, 4, 0);
        op(0, 16'h0000, 16'h0000, 1'b1, {1'b0, 1'b0, 16'h0001}, 4, 0);

        // Backpressure with new operands pending throughout
        @(negedge clk);
        drive(0, 1'b1, 16'h1111, 16'h2222, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b1, 16'hAAAA, 16'h5555, 1'b1);
        wait_valid(0, lat);
        check("bp_latency", lat, 4);
        for (int i = 0; i < 5; i++) begin
            r = rd(0);
            check("bp_out_valid", 32'(r[18]), 32'd1);
            check("bp_in_ready", 32'(r[19]), 32'd0);
            check("bp_sum", 32'(r[15:0]), 32'h3333);
            check("bp_cout_ovf", 32'(r[17:16]), 32'd0);
            @(negedge clk);
        end
        set_rdy(0, 1'b1);
        @(negedge clk);
        set_rdy(0, 1'b0);
        r = rd(0);
        check("bp_idle", 32'(r[19:18]), 32'b10);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 16'hAAAA, 16'h5555, 1'b1);
        r = rd(0);
        check("bp_captured", 32'(r[19]), 32'd0);
        wait_valid(0, lat);
        r = rd(0);
        check("bp2_sum", 32'(r[15:0]), 32'h0000);
        check("bp2_cout", 32'(r[16]), 32'd1);
        check("bp2_ovf", 32'(r[17]), 32'd0);
        set_rdy(0, 1'b1);
        @(negedge clk);
        set_rdy(0, 1'b0);

        // Reset after two chunks of a BUSY operation
        drive(0, 1'b1, 16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        r = rd(0);
        check("partial_sum", 32'(r[7:0]), 32'h45);
        rst_n = 1'b0;
        #1;
        r = rd(0);
        check("mid_rst_out_valid", 32'(r[18]), 32'd0);
        check("mid_rst_sum", 32'(r[15:0]), 32'd0);
        check("mid_rst_in_ready", 32'(r[19]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        op(0, 16'h0001, 16'h0001, 1'b0, {1'b0, 1'b0, 16'h0002}, 4, 0);

`ifdef SERIAL_ADDER_SUB_EN
        sub_r = 1'b1;
        op(0, 16'h0005, 16'h0007, 1'b0, {1'b0, 1'b0, 16'hFFFE}, 4, 0);
        op(0, 16'h8000, 16'h0001, 1'b1, {1'b1, 1'b1, 16'h7FFF}, 4, 0);
        sub_r = 1'b0;
`endif

        op(1, 16'h00FF, 16'h0001, 1'b0, {1'b0, 1'b0, 16'h0100}, 1, 0);

        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sub_r = 1'($urandom);
`endif
            op(0, ra, rb, rc, model(ra, rb, rc, sub_r), 4, $urandom_range(0, 2));
        end
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sub_r = 1'($urandom);
`endif
            op(1, ra, rb, rc, model(ra, rb, rc, sub_r), 1, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
